// File: rtl/bsg_wormhole_router_pkg.sv
// Shared wormhole types: header layout {len, cord}, link-side FSM states and the flit-count helper.
// Used by the input adapter and the packet assembler so both agree on framing.
`define DECLARE_BSG_WORMHOLE_ROUTER_HEADER_S(cord_width_mp, len_width_mp, struct_name_mp) \
  typedef struct packed { \
    logic [len_width_mp-1:0]  len; \
    logic [cord_width_mp-1:0] cord; \
  } struct_name_mp

package bsg_wormhole_router_pkg;

  typedef enum logic {eRecv, eValid} wormhole_state_e;

  // Number of flits needed to carry a packet of the given width (ceiling divide).
  function automatic int max_num_flit(input int packet_width, input int flit_width);
    return (packet_width + flit_width - 1) / flit_width;
  endfunction

endpackage

// File: rtl/bsg_wormhole_packet_assembler.sv
// Reassembles wormhole flits into one packet word; v_o rises 1 cycle after the last flit, link stalls while v_o is held.
// Length check against slot count is built only with BSG_WORMHOLE_PACKET_ASSEMBLER_LEN_CHECK_EN.
module bsg_wormhole_packet_assembler
  import bsg_wormhole_router_pkg::*;
#(
  parameter int flit_width_p        = 8,
  parameter int cord_width_p        = 4,
  parameter int len_width_p         = 2,
  parameter int max_payload_width_p = 17,
  localparam int max_packet_width_lp = max_payload_width_p + len_width_p + cord_width_p,
  localparam int max_num_flit_lp     = max_num_flit(max_packet_width_lp, flit_width_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [flit_width_p+1:0]        link_i,
  output logic [flit_width_p+1:0]        link_o,
  output logic [max_packet_width_lp-1:0] packet_o,
  output logic                           v_o,
  input  logic                           yumi_i,
  output logic                           error_o
);

  localparam int cnt_width_lp = (len_width_p > 1) ? len_width_p : 1;
  localparam int buf_width_lp = max_num_flit_lp * flit_width_p;

  typedef struct packed {
    logic                    v;
    logic                    ready_and_rev;
    logic [flit_width_p-1:0] data;
  } link_sif_s;

  `DECLARE_BSG_WORMHOLE_ROUTER_HEADER_S(cord_width_p, len_width_p, header_s);

  link_sif_s link_in, link_out;
  header_s   hdr;

  wormhole_state_e          state_q, state_d;
  logic [cnt_width_lp-1:0]  count_q, count_d;
  logic [cnt_width_lp-1:0]  len_q, len_d;
  logic [buf_width_lp-1:0]  buf_q, buf_d;
  logic                     hdr_oversize;

  assign link_in      = link_i;
  assign link_o       = link_out;
  assign hdr          = link_in.data[cord_width_p+len_width_p-1:0];
  assign hdr_oversize = (int'(hdr.len) > max_num_flit_lp - 1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    buf_d   = buf_q;
    case (state_q)
      eRecv: begin
        if (link_in.v) begin
          if (count_q == '0) begin
            // Header clears the whole buffer so short packets never show stale upper slots.
            buf_d                   = '0;
            buf_d[flit_width_p-1:0] = link_in.data;
            len_d                   = cnt_width_lp'(hdr.len);
            if (hdr.len == '0) state_d = eValid;
            else               count_d = cnt_width_lp'(1);
          end else begin
            // Slots past the buffer simply match no index, so oversized bodies are consumed and dropped.
            for (int k = 1; k < max_num_flit_lp; k++) begin
              if (k == int'(count_q)) buf_d[k*flit_width_p +: flit_width_p] = link_in.data;
            end
            if (count_q == len_q) begin
              state_d = eValid;
              count_d = '0;
            end else begin
              count_d = count_q + cnt_width_lp'(1);
            end
          end
        end
      end
      eValid: if (yumi_i) state_d = eRecv;
      default: state_d = eRecv;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eRecv;
      count_q <= '0;
      len_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
    end
  end

  wire hdr_accept = link_in.v && (state_q == eRecv) && (count_q == '0);

`ifdef BSG_WORMHOLE_PACKET_ASSEMBLER_LEN_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (hdr_accept && hdr_oversize) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && hdr_accept && hdr_oversize)
      $error("wormhole packet assembler: header len %0d exceeds %0d body flits", hdr.len, max_num_flit_lp - 1);
  end
`endif

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  always_comb begin
    link_out               = '0;
    link_out.ready_and_rev = (state_q == eRecv);
  end

  assign v_o      = (state_q == eValid);
  assign packet_o = buf_q[max_packet_width_lp-1:0];

  logic unused;
  assign unused = ^{link_in.ready_and_rev, hdr.cord, hdr_oversize, hdr_accept, buf_q};

endmodule
